// File: rtl/core_sequencer.sv
// core_sequencer: per-core instruction sequencer.
// Steps each instruction through FETCH, DECODE, REQUEST, WAIT, EXECUTE and UPDATE.
// Memory ops stall in WAIT until every active lane reports completion.
// UPDATE commits the lowest active lane's next PC and flags lane disagreement.
// A RET retires the block into a sticky DONE state.
module core_sequencer #(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int PC_BITS           = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [THREADS_PER_BLOCK-1:0]         thread_enable,
    input  logic                                 fetch_valid,
    input  logic                                 decoded_mem_read_enable,
    input  logic                                 decoded_mem_write_enable,
    input  logic                                 decoded_smem_read_enable,
    input  logic                                 decoded_smem_write_enable,
    input  logic                                 decoded_ret,
    input  logic [THREADS_PER_BLOCK-1:0]         lsu_done,
    input  logic [THREADS_PER_BLOCK*PC_BITS-1:0] next_pc,
    output logic [2:0]                           core_state,
    output logic [PC_BITS-1:0]                   current_pc,
    output logic                                 fetch_req,
    output logic                                 done,
    output logic                                 diverged,
    output logic [15:0]                          instr_count
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'b000,
        S_FETCH   = 3'b001,
        S_DECODE  = 3'b010,
        S_REQUEST = 3'b011,
        S_WAIT    = 3'b100,
        S_EXECUTE = 3'b101,
        S_UPDATE  = 3'b110,
        S_DONE    = 3'b111
    } state_t;

    state_t                       state_q, state_d;
    logic [THREADS_PER_BLOCK-1:0] mask_q, mask_d;
    logic [PC_BITS-1:0]           pc_q, pc_d;
    logic                         div_q, div_d;
    logic [15:0]                  cnt_q, cnt_d;

    logic                         mem_op;
    logic                         lanes_ready;
    logic [PC_BITS-1:0]           lead_pc;
    logic                         lead_found;
    logic                         any_diff;

    assign mem_op      = decoded_mem_read_enable  | decoded_mem_write_enable |
                         decoded_smem_read_enable | decoded_smem_write_enable;
    assign lanes_ready = ((lsu_done & mask_q) == mask_q);

    // Pick the lowest active lane's next PC and detect whether any active lane disagrees.
    always_comb begin
        lead_pc    = '0;
        lead_found = 1'b0;
        any_diff   = 1'b0;
        for (int unsigned i = 0; i < THREADS_PER_BLOCK; i++) begin
            if (mask_q[i] && !lead_found) begin
                lead_pc    = next_pc[i*PC_BITS +: PC_BITS];
                lead_found = 1'b1;
            end
        end
        for (int unsigned i = 0; i < THREADS_PER_BLOCK; i++) begin
            if (mask_q[i] && (next_pc[i*PC_BITS +: PC_BITS] != lead_pc)) begin
                any_diff = 1'b1;
            end
        end
    end

    // State and datapath registers; reset discards all in-flight state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            mask_q  <= '0;
            pc_q    <= '0;
            div_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            pc_q    <= pc_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic for the instruction pipeline walk.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (thread_enable != '0) ? S_FETCH : S_DONE;
                end
            end
            S_FETCH:   if (fetch_valid) state_d = S_DECODE;
            S_DECODE:  state_d = S_REQUEST;
            S_REQUEST: state_d = S_WAIT;
            S_WAIT:    if (!mem_op || lanes_ready) state_d = S_EXECUTE;
            S_EXECUTE: state_d = S_UPDATE;
            S_UPDATE:  state_d = decoded_ret ? S_DONE : S_FETCH;
            S_DONE:    state_d = S_DONE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Datapath updates: block launch loads the mask and clears the PC; UPDATE commits.
    always_comb begin
        mask_d = mask_q;
        pc_d   = pc_q;
        div_d  = div_q;
        cnt_d  = cnt_q;
        if (state_q == S_IDLE && start && thread_enable != '0) begin
            mask_d = thread_enable;
            pc_d   = '0;
        end
        if (state_q == S_UPDATE) begin
            cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
            if (!decoded_ret) begin
                pc_d  = lead_pc;
                div_d = any_diff;
            end
        end
    end

    // Outputs decoded from the current state and registers.
    always_comb begin
        core_state  = state_q;
        fetch_req   = (state_q == S_FETCH);
        done        = (state_q == S_DONE);
        current_pc  = pc_q;
        diverged    = div_q;
        instr_count = cnt_q;
    end

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: hand-written vector table, corner sequences,
// and randomized blocks checked against a transaction-level model.
module tb_core_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  thread_enable;
    logic        fetch_valid;
    logic        dmr, dmw, dsr, dsw, dret;
    logic [3:0]  lsu_done;
    logic [31:0] next_pc;
    logic [2:0]  core_state;
    logic [7:0]  current_pc;
    logic        fetch_req;
    logic        done;
    logic        diverged;
    logic [15:0] instr_count;

    core_sequencer #(.THREADS_PER_BLOCK(4), .PC_BITS(8)) dut (
        .clk                       (clk),
        .reset                     (reset),
        .start                     (start),
        .thread_enable             (thread_enable),
        .fetch_valid               (fetch_valid),
        .decoded_mem_read_enable   (dmr),
        .decoded_mem_write_enable  (dmw),
        .decoded_smem_read_enable  (dsr),
        .decoded_smem_write_enable (dsw),
        .decoded_ret               (dret),
        .lsu_done                  (lsu_done),
        .next_pc                   (next_pc),
        .core_state                (core_state),
        .current_pc                (current_pc),
        .fetch_req                 (fetch_req),
        .done                      (done),
        .diverged                  (diverged),
        .instr_count               (instr_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model state
    logic [3:0] m_mask;
    logic [7:0] m_pc;
    int         m_count;
    bit         m_div;
    bit         noise;
    int         o_wait;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        start = 0; thread_enable = 0; fetch_valid = 0;
        dmr = 0; dmw = 0; dsr = 0; dsw = 0; dret = 0;
        lsu_done = 0; next_pc = 0;
        #2 reset = 1;
        #1;
        check("rst_state", core_state, 3'b000);
        check("rst_pc", current_pc, 8'h00);
        check("rst_count", instr_count, 16'h0);
        check("rst_done", done, 1'b0);
        check("rst_div", diverged, 1'b0);
        check("rst_fetch_req", fetch_req, 1'b0);
        reset = 0;
        m_mask = 0; m_pc = 0; m_count = 0; m_div = 0;
    endtask

    task automatic start_block(input logic [3:0] mask);
        thread_enable = mask;
        start = 1;
        tick();
        start = 0;
        thread_enable = $urandom;
        m_mask = mask;
        m_pc = 0;
        check("start_state", core_state, (mask != 0) ? 3'b001 : 3'b111);
        check("start_pc", current_pc, 8'h00);
    endtask

    // Drive one instruction from FETCH through UPDATE and compare with the model.
    // kind: 0 none, 1 LDR, 2 STR, 3 LDS, 4 STS. dly: per-lane WAIT cycle at which lsu_done rises.
    task automatic run_instr(input int kind, input bit ret, input int fd,
                             input logic [15:0] dly, input logic [31:0] npc);
        logic [2:0] exp_q[$];
        logic [2:0] got_q[$];
        logic [7:0] vals[$];
        int fcnt = 0;
        int wcnt = 0;
        int w;
        int first_bad;
        bit seen_upd = 0;
        bit freq_ok = 1;
        logic [2:0] s;

        dmr = (kind == 1); dmw = (kind == 2); dsr = (kind == 3); dsw = (kind == 4);
        dret = ret;
        next_pc = npc;

        // Expected WAIT length: one cycle, or until the slowest active lane is done.
        w = 1;
        if (kind != 0) begin
            int mx = 0;
            for (int i = 0; i < 4; i++)
                if (m_mask[i] && int'(dly[4*i +: 4]) > mx) mx = int'(dly[4*i +: 4]);
            w = mx + 1;
        end
        for (int k = 0; k <= fd; k++) exp_q.push_back(3'b001);
        exp_q.push_back(3'b010);
        exp_q.push_back(3'b011);
        for (int k = 0; k < w; k++) exp_q.push_back(3'b100);
        exp_q.push_back(3'b101);
        exp_q.push_back(3'b110);

        for (int cyc = 0; cyc < 100 && !seen_upd; cyc++) begin
            s = core_state;
            got_q.push_back(s);
            if (fetch_req !== (s == 3'b001)) freq_ok = 0;
            if (s == 3'b001) begin
                fetch_valid = (fcnt >= fd);
                fcnt++;
            end else begin
                fetch_valid = noise ? 1'($urandom % 2) : 1'b0;
            end
            for (int i = 0; i < 4; i++) begin
                if (m_mask[i]) lsu_done[i] = (s == 3'b100) && (wcnt >= int'(dly[4*i +: 4]));
                else           lsu_done[i] = noise ? 1'($urandom % 2) : 1'b0;
            end
            if (s == 3'b100) wcnt++;
            if (noise) begin
                start = 1'($urandom % 2);
                thread_enable = $urandom;
            end
            if (s == 3'b110) seen_upd = 1;
            tick();
        end
        start = 0;
        fetch_valid = 0;
        lsu_done = 0;

        check("update_reached", seen_upd, 1'b1);
        check("trace_len", got_q.size(), exp_q.size());
        first_bad = -1;
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++)
            if (first_bad < 0 && got_q[k] !== exp_q[k]) first_bad = k;
        check("trace_first_bad_idx", first_bad, -1);
        check("fetch_req_track", freq_ok, 1'b1);
        o_wait = 0;
        foreach (got_q[k]) if (got_q[k] == 3'b100) o_wait++;

        // Model commit
        m_count = (m_count >= 65535) ? 65535 : m_count + 1;
        if (!ret) begin
            for (int i = 0; i < 4; i++) if (m_mask[i]) vals.push_back(npc[8*i +: 8]);
            m_pc = vals[0];
            m_div = 0;
            foreach (vals[k]) if (vals[k] != vals[0]) m_div = 1;
        end

        check("post_state", core_state, ret ? 3'b111 : 3'b001);
        check("post_pc", current_pc, m_pc);
        check("post_div", diverged, m_div);
        check("post_count", instr_count, m_count);
        check("post_done", done, ret);
    endtask

    typedef struct {
        bit          newblk;
        logic [3:0]  mask;
        int          kind;
        bit          ret;
        int          fd;
        logic [15:0] dly;
        logic [31:0] npc;
        int          exp_wait;
        logic [7:0]  exp_pc;
        bit          exp_div;
        int          exp_cnt;
    } vec_t;

    vec_t tbl[8];

    initial begin
        reset = 0;
        noise = 0;
        apply_reset();

        tbl[0] = '{1'b1, 4'hF, 0, 1'b0, 0, 16'h0000, 32'h01010101, 1, 8'h01, 1'b0, 1};
        tbl[1] = '{1'b0, 4'hF, 1, 1'b0, 2, 16'h0000, 32'h02020202, 1, 8'h02, 1'b0, 2};
        tbl[2] = '{1'b0, 4'hF, 2, 1'b0, 0, 16'h3210, 32'h05050905, 4, 8'h05, 1'b1, 3};
        tbl[3] = '{1'b0, 4'hF, 0, 1'b1, 1, 16'h0000, 32'h77777777, 1, 8'h05, 1'b1, 4};
        tbl[4] = '{1'b1, 4'h5, 1, 1'b0, 0, 16'hF4F1, 32'h33103310, 5, 8'h10, 1'b0, 1};
        tbl[5] = '{1'b1, 4'h6, 0, 1'b0, 0, 16'h0000, 32'h090507AA, 1, 8'h07, 1'b1, 1};
        tbl[6] = '{1'b0, 4'h6, 4, 1'b0, 0, 16'h0000, 32'hFFFFFFFF, 1, 8'hFF, 1'b0, 2};
        tbl[7] = '{1'b0, 4'h6, 0, 1'b0, 0, 16'h0000, 32'h00000000, 1, 8'h00, 1'b0, 3};

        for (int i = 0; i < 8; i++) begin
            if (tbl[i].newblk) begin
                apply_reset();
                start_block(tbl[i].mask);
            end
            run_instr(tbl[i].kind, tbl[i].ret, tbl[i].fd, tbl[i].dly, tbl[i].npc);
            check("tbl_wait", o_wait, tbl[i].exp_wait);
            check("tbl_pc", current_pc, tbl[i].exp_pc);
            check("tbl_div", diverged, tbl[i].exp_div);
            check("tbl_count", instr_count, tbl[i].exp_cnt);
            if (tbl[i].ret) begin
                // A start pulse in DONE must change nothing.
                thread_enable = 4'hF;
                start = 1;
                tick();
                start = 0;
                repeat (3) tick();
                check("done_start_state", core_state, 3'b111);
                check("done_start_done", done, 1'b1);
                check("done_start_count", instr_count, tbl[i].exp_cnt);
                check("done_start_pc", current_pc, tbl[i].exp_pc);
                check("done_start_fetch_req", fetch_req, 1'b0);
            end
        end

        // Reset in the middle of a memory WAIT with no lane completing.
        begin
            bit reached = 0;
            apply_reset();
            start_block(4'hF);
            run_instr(0, 1'b0, 0, 16'h0000, 32'h03030303);
            dmr = 1; dret = 0; lsu_done = 0; fetch_valid = 1;
            for (int k = 0; k < 10 && !reached; k++) begin
                if (core_state == 3'b100) reached = 1;
                else tick();
            end
            check("midwait_reached", reached, 1'b1);
            repeat (3) tick();
            check("midwait_stall", core_state, 3'b100);
            #2 reset = 1;
            #1;
            check("midwait_rst_state", core_state, 3'b000);
            check("midwait_rst_pc", current_pc, 8'h00);
            check("midwait_rst_count", instr_count, 16'h0);
            check("midwait_rst_done", done, 1'b0);
            reset = 0;
            dmr = 0; fetch_valid = 0;
        end

        // Start with no active threads goes straight to DONE without fetching.
        begin
            bit saw_fetch = 0;
            apply_reset();
            thread_enable = 4'h0;
            start = 1;
            tick();
            start = 0;
            check("empty_state", core_state, 3'b111);
            check("empty_done", done, 1'b1);
            for (int k = 0; k < 4; k++) begin
                if (core_state == 3'b001 || fetch_req) saw_fetch = 1;
                tick();
            end
            check("empty_no_fetch", saw_fetch, 1'b0);
            check("empty_hold", core_state, 3'b111);
        end

        // Randomized blocks with noise on inactive lanes, unused inputs and start.
        noise = 1;
        for (int b = 0; b < 6; b++) begin
            int n;
            apply_reset();
            start_block(4'($urandom_range(1, 15)));
            n = $urandom_range(3, 8);
            for (int j = 0; j < n; j++) begin
                logic [31:0] npc;
                if ($urandom % 2) npc = {4{8'($urandom)}};
                else              npc = $urandom;
                run_instr($urandom_range(0, 4), (j == n - 1), $urandom_range(0, 3),
                          16'($urandom), npc);
            end
        end
        noise = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #600000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
